// File: rtl/dap_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dap_shift_pkg
//  Brief   : Shared sizing and state encoding for the DAP serial bit shifter.
//  Revision: 1.0 - initial release
// ============================================================================
package dap_shift_pkg;

  localparam int MAX_BITS_DEF = 64;
  localparam int CNT_W_DEF    = $clog2(MAX_BITS_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dap_bit_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : dap_bit_shifter
//  Brief   : Shifts a 1..MAX_BITS command LSB-first onto one IO line on SCLK
//            strobes and captures the same number of bits from the input.
//            Macro DAP_SHIFT_PARK_EN keeps io_out/io_oe parked after a command.
//  Revision: 1.0 - initial release
// ============================================================================
module dap_bit_shifter
  import dap_shift_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk_pulse,
  input  logic                sclk_delay_pulse,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_W-1:0]    cmd_nbits,
  input  logic                cmd_drive,
  input  logic [MAX_BITS-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_rdata,
  output logic                io_out,
  output logic                io_oe,
  input  logic                io_in,
  output logic                busy
);

  localparam int               IDX_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t              state_q;
  logic [CNT_W-1:0]    nbits_q;
  logic                drive_q;
  logic [MAX_BITS-1:0] wdata_q;
  logic [MAX_BITS-1:0] rdata_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic [CNT_W-1:0]    in_cnt_q;
  logic                io_out_q;
  logic                io_oe_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic [CNT_W-1:0]    nbits_d;
  logic [CNT_W-1:0]    out_cnt_d;
  logic [CNT_W-1:0]    in_cnt_d;
  logic                pulse_fire;
  logic                smp_fire;

  // The sample gate compares against out_cnt after this cycle's pulse, so a
  // coincident strobe pair drives and samples the same bit.
  always_comb begin
    nbits_d    = (cmd_nbits > MAX_CNT) ? MAX_CNT : cmd_nbits;
    pulse_fire = 1'b0;
    smp_fire   = 1'b0;
    out_cnt_d  = out_cnt_q;
    in_cnt_d   = in_cnt_q;
    if ((state_q == ST_ARM || state_q == ST_SHIFT) && sclk_pulse &&
        (out_cnt_q < nbits_q)) begin
      pulse_fire = 1'b1;
      out_cnt_d  = out_cnt_q + ONE_CNT;
    end
    if ((state_q == ST_SHIFT || (state_q == ST_ARM && pulse_fire)) &&
        sclk_delay_pulse && (in_cnt_q < out_cnt_d)) begin
      smp_fire = 1'b1;
      in_cnt_d = in_cnt_q + ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      nbits_q     <= '0;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      out_cnt_q   <= '0;
      in_cnt_q    <= '0;
      io_out_q    <= 1'b0;
      io_oe_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            nbits_q     <= nbits_d;
            drive_q     <= cmd_drive;
            wdata_q     <= cmd_wdata;
            rdata_q     <= '0;
            out_cnt_q   <= '0;
            in_cnt_q    <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (nbits_d == '0) ? ST_DONE : ST_ARM;
          end
        end
        ST_ARM, ST_SHIFT: begin
          out_cnt_q <= out_cnt_d;
          in_cnt_q  <= in_cnt_d;
          if (pulse_fire) begin
            io_out_q <= wdata_q[out_cnt_q[IDX_W-1:0]];
            io_oe_q  <= drive_q;
            state_q  <= ST_SHIFT;
          end
          if (smp_fire) begin
            rdata_q[in_cnt_q[IDX_W-1:0]] <= io_in;
          end
          if (smp_fire && (in_cnt_d == nbits_q)) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
`ifdef DAP_SHIFT_PARK_EN
`else
            io_oe_q     <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          // A zero-bit command arrives here with rsp_valid still low.
          if (rsp_valid_q && rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dap_bit_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dap_bit_shifter
//  Brief   : Directed self-checking bench for dap_bit_shifter.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dap_bit_shifter;

  localparam int CW = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk_pulse = 1'b0;
  logic        sclk_delay_pulse = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [CW-1:0] cmd_nbits = '0;
  logic        cmd_drive = 1'b0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        io_out;
  logic        io_oe;
  logic        io_in = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  dap_bit_shifter dut (
    .clk              (clk),
    .reset            (reset),
    .sclk_pulse       (sclk_pulse),
    .sclk_delay_pulse (sclk_delay_pulse),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_nbits        (cmd_nbits),
    .cmd_drive        (cmd_drive),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .io_out           (io_out),
    .io_oe            (io_oe),
    .io_in            (io_in),
    .busy             (busy)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          period = 4;
  int          dly = 0;
  int          ph = 0;
  int          opc = 0;
  int          dcnt = 0;
  int          nb = 0;
  int          pend_idx = 0;
  int          n_samp = 0;
  bit          gen_en = 1'b0;
  bit          pending = 1'b0;
  bit          cur_drive = 1'b0;
  bit          exp_oe = 1'b0;
  bit          seen_rsp = 1'b0;
  logic [63:0] pat = '0;
  logic [63:0] exp_w = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and verify the bit driven by
  // the previous cycle's pulse.
  task automatic tick_edge();
    @(posedge clk);
    #1;
    if (pending) begin
      check("io_out_bit", 64'(io_out), 64'(exp_w[pend_idx]));
      if (!(cur_drive && pend_idx == nb - 1))
        check("io_oe_bit", 64'(io_oe), 64'(exp_oe));
      pending = 1'b0;
    end
  endtask

  // Strobes for the current cycle; the line carries pat bit k at sample k.
  task automatic drive_strobes();
    sclk_pulse       = 1'b0;
    sclk_delay_pulse = 1'b0;
    if (gen_en) begin
      sclk_pulse       = (ph % period) == 0;
      sclk_delay_pulse = (ph % period) == dly;
      ph++;
    end
    if (sclk_pulse && opc < nb) begin
      pending  = 1'b1;
      pend_idx = opc;
    end
    if (sclk_pulse) opc++;
    if (sclk_delay_pulse) begin
      io_in = (dcnt < 64) ? pat[dcnt] : 1'b0;
      dcnt++;
    end
  endtask

  task automatic step();
    tick_edge();
    drive_strobes();
  endtask

  task automatic do_cmd(input int nbits, input bit drive, input logic [63:0] wdata);
    sclk_pulse       = 1'b0;
    sclk_delay_pulse = 1'b0;
    cmd_valid = 1'b1;
    cmd_nbits = CW'(nbits);
    cmd_drive = drive;
    cmd_wdata = wdata;
    nb        = (nbits > 64) ? 64 : nbits;
    cur_drive = drive;
    exp_oe    = drive;
    exp_w     = wdata;
    opc = 0; dcnt = 0; ph = 0; pending = 1'b0;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    tick_edge();
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    drive_strobes();
  endtask

  task automatic wait_rsp(input int budget, output int samples);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick_edge();
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      drive_strobes();
    end
    samples = dcnt;
    check("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
    if (got) drive_strobes();
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick_edge();
    rsp_ready = 1'b0;
    check("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    drive_strobes();
  endtask

  initial begin
    // Reset state
    tick_edge();
    tick_edge();
    reset = 1'b0;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_io_oe",     64'(io_oe),     64'd0);
    check("rst_io_out",    64'(io_out),    64'd0);
    check("rst_rdata",     rsp_rdata,      64'd0);

    // Drive 0xA5, coincident strobes, last bit is 1 (park behaviour)
    period = 4; dly = 0; gen_en = 1'b1; pat = 64'hA5;
    do_cmd(8, 1'b1, 64'hA5);
    wait_rsp(200, n_samp);
    check("t1_rdata", rsp_rdata, 64'hA5);
    check("t1_done_io_out", 64'(io_out), 64'd1);
`ifdef DAP_SHIFT_PARK_EN
    check("t1_done_io_oe", 64'(io_oe), 64'd1);
`else
    check("t1_done_io_oe", 64'(io_oe), 64'd0);
`endif
    handshake();
    check("t1_idle_io_out", 64'(io_out), 64'd1);
`ifdef DAP_SHIFT_PARK_EN
    check("t1_idle_io_oe", 64'(io_oe), 64'd1);
`else
    check("t1_idle_io_oe", 64'(io_oe), 64'd0);
`endif

    // Input-only 32 bits, delay 3, then backpressure for 20 cycles
    period = 4; dly = 3; gen_en = 1'b1; pat = 64'hDEADBEEF;
    do_cmd(32, 1'b0, 64'd0);
    wait_rsp(400, n_samp);
    check("t2_rdata", rsp_rdata, 64'hDEADBEEF);
    check("t2_io_oe", 64'(io_oe), 64'd0);
    repeat (20) step();
    check("bp_rdata",     rsp_rdata,       64'hDEADBEEF);
    check("bp_cmd_ready", 64'(cmd_ready),  64'd0);
    check("bp_rsp_valid", 64'(rsp_valid),  64'd1);
    handshake();

    // Zero-bit command: response two cycles after accept
    gen_en = 1'b0;
    do_cmd(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_rsp_valid_a1", 64'(rsp_valid), 64'd0);
    tick_edge();
    check("t3_rsp_valid_a2", 64'(rsp_valid), 64'd1);
    check("t3_rdata",        rsp_rdata,      64'd0);
    drive_strobes();
    handshake();

    // Oversize count clamps to 64 samples
    period = 3; dly = 1; gen_en = 1'b1; pat = 64'hFEDC_BA98_7654_3210;
    do_cmd(100, 1'b0, 64'd0);
    wait_rsp(400, n_samp);
    check("t4_samples", 64'(n_samp), 64'd64);
    check("t4_rdata",   rsp_rdata,   64'hFEDC_BA98_7654_3210);
    handshake();

    // Reset after 5 of 16 bits
    period = 4; dly = 2; gen_en = 1'b1; pat = 64'd0;
    do_cmd(16, 1'b1, 64'h1234);
    for (int i = 0; i < 100 && opc < 5; i++) step();
    tick_edge();
    reset = 1'b1; gen_en = 1'b0;
    drive_strobes();
    tick_edge();
    reset = 1'b0;
    check("mr_io_out",    64'(io_out),    64'd0);
    check("mr_io_oe",     64'(io_oe),     64'd0);
    check("mr_busy",      64'(busy),      64'd0);
    check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mr_rdata",     rsp_rdata,      64'd0);
    nb = 0; gen_en = 1'b1; seen_rsp = 1'b0;
    drive_strobes();
    for (int i = 0; i < 12; i++) begin
      step();
      seen_rsp = seen_rsp | rsp_valid;
    end
    check("mr_no_rsp", 64'(seen_rsp), 64'd0);

    // Clean 4-bit command afterwards
    period = 2; dly = 0; gen_en = 1'b1; pat = 64'hC;
    do_cmd(4, 1'b1, 64'h9);
    wait_rsp(100, n_samp);
    check("t5_rdata", rsp_rdata, 64'hC);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
